// File: rtl/usb4_timer_pkg.sv
// rtl/usb4_timer_pkg.sv - shared constants for the USB4 timeout timer bank
//
// Purpose: default timeout limits, channel index assignments and the default
// prescaler divisor used by timeout_timer_bank and its consumers.
// Ports: none (package).
package usb4_timer_pkg;

  // sb_clk cycles per slow tick (1 MHz sideband clock -> 1 kHz tick)
  localparam int PRESC_DIV_DEFAULT = 1000;

  // Channel assignment within the bank
  localparam int CH_TDISCONNECT_TX  = 0;
  localparam int CH_TDISCONNECT_RX  = 1;
  localparam int CH_TCONNECT_RX     = 2;
  localparam int CH_TDISABLED       = 3;
  localparam int CH_TTRAINING_ERROR = 4;
  localparam int CH_TGEN4_TS1       = 5;
  localparam int CH_TGEN4_TS2       = 6;
  localparam int CH_TCMD_RESPONSE   = 7;

  // Default limits, in units of the channel's selected time base
  localparam int TDISCONNECT_TX  = 1;
  localparam int TDISCONNECT_RX  = 14;
  localparam int TCONNECT_RX     = 25;
  localparam int TDISABLED       = 10;
  localparam int TTRAINING_ERROR = 500;
  localparam int TGEN4_TS1       = 400;
  localparam int TGEN4_TS2       = 200;
  localparam int TCMD_RESPONSE   = 200;

  // Default limit for a given channel index; 0 for an unassigned index
  function automatic int default_limit(input int ch);
    case (ch)
      CH_TDISCONNECT_TX:  return TDISCONNECT_TX;
      CH_TDISCONNECT_RX:  return TDISCONNECT_RX;
      CH_TCONNECT_RX:     return TCONNECT_RX;
      CH_TDISABLED:       return TDISABLED;
      CH_TTRAINING_ERROR: return TTRAINING_ERROR;
      CH_TGEN4_TS1:       return TGEN4_TS1;
      CH_TGEN4_TS2:       return TGEN4_TS2;
      CH_TCMD_RESPONSE:   return TCMD_RESPONSE;
      default:            return 0;
    endcase
  endfunction

endpackage

// File: rtl/timeout_timer_bank_if.sv
// rtl/timeout_timer_bank_if.sv - channel control/status bundle for the timeout timer bank
//
// Purpose: groups the per-channel controls and the status outputs of
// timeout_timer_bank.
// Signals:
//   ch_run, ch_restart, ch_tick_sel [NUM_CH]  controls (master -> slave)
//   ch_limit [NUM_CH*CNT_W]                   per-channel limit, ch i at [i*CNT_W +: CNT_W]
//   ch_timeout, ch_expire_p [NUM_CH]          status (slave -> master)
//   any_timeout, slow_tick                    status (slave -> master)
interface timeout_timer_bank_if #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0]       ch_run;
  logic [NUM_CH-1:0]       ch_restart;
  logic [NUM_CH-1:0]       ch_tick_sel;
  logic [NUM_CH*CNT_W-1:0] ch_limit;
  logic [NUM_CH-1:0]       ch_timeout;
  logic [NUM_CH-1:0]       ch_expire_p;
  logic                    any_timeout;
  logic                    slow_tick;

  modport master (
    output ch_run, ch_restart, ch_tick_sel, ch_limit,
    input  ch_timeout, ch_expire_p, any_timeout, slow_tick
  );

  modport slave (
    input  ch_run, ch_restart, ch_tick_sel, ch_limit,
    output ch_timeout, ch_expire_p, any_timeout, slow_tick
  );
endinterface

// File: rtl/timeout_channel.sv
// rtl/timeout_channel.sv - one saturating timeout counter with level and pulse outputs
//
// Purpose: counts while run is high, compares against limit and registers the
// timeout level plus a one-cycle pulse on its rising edge.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   run            level; counter clears while low
//   restart        pulse; zero the counter, keep running
//   advance        count enable for this cycle (every clock or slow tick)
//   limit          timeout threshold
//   timeout        registered level: run && !restart && cnt >= limit
//   expire_p       registered pulse on each rising edge of timeout
module timeout_channel #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             restart,
  input  logic             advance,
  input  logic [CNT_W-1:0] limit,
  output logic             timeout,
  output logic             expire_p
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             expire_p_q, expire_p_d;

  always_comb begin
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
    expire_p_d = 1'b0;

    // Run-low and restart both clear; the counter stops at the limit and
    // simply holds if the limit is later lowered beneath it.
    if (!run || restart) begin
      cnt_d = '0;
    end else if (advance && (cnt_q < limit)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Compare uses the pre-edge count, so timeout lags the count by one stage.
    timeout_d  = run && !restart && (cnt_q >= limit);
    expire_p_d = timeout_d && !timeout_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      expire_p_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      expire_p_q <= expire_p_d;
    end
  end

  assign timeout  = timeout_q;
  assign expire_p = expire_p_q;

endmodule

// File: rtl/timeout_timer_bank.sv
// rtl/timeout_timer_bank.sv - multi-channel timeout generator with shared prescaler
//
// Purpose: NUM_CH independent timeout channels in the sb_clk domain, each
// counting either every sb_clk or on the shared prescaled slow tick.
// Ports:
//   sb_clk   sideband clock, rising edge
//   rst      asynchronous, active-low reset
//   bus      timeout_timer_bank_if.slave: per-channel run/restart/tick_sel/limit
//            in; ch_timeout, ch_expire_p, any_timeout, slow_tick out
module timeout_timer_bank
  import usb4_timer_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int CNT_W     = 16,
  parameter int PRESC_DIV = PRESC_DIV_DEFAULT,
  parameter int PRESC_W   = 10
) (
  input  logic                 sb_clk,
  input  logic                 rst,
  timeout_timer_bank_if.slave  bus
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic               slow_tick_q, slow_tick_d;
  logic               any_timeout_q, any_timeout_d;
  logic [NUM_CH-1:0]  ch_timeout_w;
  logic [NUM_CH-1:0]  ch_expire_p_w;

  // Free-running prescaler; channel activity never touches it.
  always_comb begin
    presc_cnt_d   = presc_cnt_q + PRESC_W'(1);
    slow_tick_d   = 1'b0;
    any_timeout_d = |ch_timeout_w;
    if (presc_cnt_q == PRESC_LAST) begin
      presc_cnt_d = '0;
      slow_tick_d = 1'b1;
    end
  end

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      presc_cnt_q   <= '0;
      slow_tick_q   <= 1'b0;
      any_timeout_q <= 1'b0;
    end else begin
      presc_cnt_q   <= presc_cnt_d;
      slow_tick_q   <= slow_tick_d;
      any_timeout_q <= any_timeout_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timeout_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk      (sb_clk),
      .rst      (rst),
      .run      (bus.ch_run[i]),
      .restart  (bus.ch_restart[i]),
      .advance  (bus.ch_tick_sel[i] ? slow_tick_q : 1'b1),
      .limit    (bus.ch_limit[i*CNT_W +: CNT_W]),
      .timeout  (ch_timeout_w[i]),
      .expire_p (ch_expire_p_w[i])
    );
  end

  assign bus.ch_timeout  = ch_timeout_w;
  assign bus.ch_expire_p = ch_expire_p_w;
  assign bus.any_timeout = any_timeout_q;
  assign bus.slow_tick   = slow_tick_q;

endmodule

// File: tb/tb_timeout_timer_bank.sv
// tb/tb_timeout_timer_bank.sv - self-checking bench for timeout_timer_bank
module tb_timeout_timer_bank;

  localparam int NUM_CH = 8;
  localparam int CNT_W  = 16;
  localparam int DIV    = 1000;
  localparam int PW     = 10;

  logic sb_clk = 1'b0;
  logic rst    = 1'b0;

  timeout_timer_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  timeout_timer_bank #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .PRESC_DIV (DIV),
    .PRESC_W   (PW)
  ) dut (
    .sb_clk (sb_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 sb_clk = ~sb_clk;

  int n_assert = 0;
  int n_fail   = 0;
  int e;

  // Reference model: integer count per channel, time measured in edges since reset release.
  int              m_cnt [NUM_CH];
  bit [NUM_CH-1:0] m_to, m_ep;
  bit              m_any, m_slow;
  int              m_edges;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
    m_to = '0; m_ep = '0; m_any = 0; m_slow = 0; m_edges = 0;
  endtask

  task automatic model_edge();
    int lim;
    bit nt, adv;
    if (!rst) return;
    m_edges++;
    m_any = (m_to != '0);
    for (int i = 0; i < NUM_CH; i++) begin
      lim = int'(bus.ch_limit[i*CNT_W +: CNT_W]);
      adv = !bus.ch_tick_sel[i] || m_slow;
      nt  = bus.ch_run[i] && !bus.ch_restart[i] && (m_cnt[i] >= lim);
      if (!bus.ch_run[i] || bus.ch_restart[i]) m_cnt[i] = 0;
      else if (adv && m_cnt[i] < lim) m_cnt[i] = m_cnt[i] + 1;
      m_ep[i] = nt && !m_to[i];
      m_to[i] = nt;
    end
    m_slow = (m_edges % DIV) == 0;
  endtask

  task automatic check_all();
    chk("model_cmp", 32'({bus.ch_timeout, bus.ch_expire_p, bus.any_timeout, bus.slow_tick}),
        32'({m_to, m_ep, m_any, m_slow}));
  endtask

  task automatic tick();
    @(posedge sb_clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_lim(input int ch, input int val);
    bus.ch_limit[ch*CNT_W +: CNT_W] = CNT_W'(val);
  endtask

  task automatic run_until(input int ch, input int max, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!bus.ch_timeout[ch] && cnt < max);
  endtask

  initial begin
    bus.ch_run      = '0;
    bus.ch_restart  = '0;
    bus.ch_tick_sel = '0;
    bus.ch_limit    = '0;
    model_reset();

    // 1: reset, then prescaler period
    repeat (3) tick();
    rst = 1'b1;
    e = 0;
    do begin tick(); e++; end while (!bus.slow_tick && e < 3*DIV);
    chk("slow_tick_first", e, DIV);
    e = 0;
    do begin tick(); e++; end while (!bus.slow_tick && e < 3*DIV);
    chk("slow_tick_period", e, DIV);

    // 2: ch0 raw clock, limit 14
    set_lim(0, 14);
    bus.ch_run[0] = 1'b1;
    run_until(0, 100, e);
    chk("t2_latency", e, 15);
    chk("t2_pulse_hi", bus.ch_expire_p[0], 1);
    tick();
    chk("t2_pulse_lo", bus.ch_expire_p[0], 0);
    chk("t2_level_held", bus.ch_timeout[0], 1);
    bus.ch_run[0] = 1'b0;
    tick();
    chk("t2_run_fall", bus.ch_timeout[0], 0);
    chk("t2_no_fall_pulse", bus.ch_expire_p[0], 0);

    // 3: ch1 slow tick, limit 10
    set_lim(1, 10);
    bus.ch_tick_sel[1] = 1'b1;
    bus.ch_run[1] = 1'b1;
    run_until(1, 12000, e);
    chk("t3_window", (e >= 9001 && e <= 10001), 1);
    bus.ch_run[1] = 1'b0;
    tick();
    chk("t3_run_fall", bus.ch_timeout[1], 0);

    // 4: ch2 restart, lowered limit, raised limit
    set_lim(2, 25);
    bus.ch_run[2] = 1'b1;
    repeat (20) tick();
    bus.ch_restart[2] = 1'b1;
    tick();
    bus.ch_restart[2] = 1'b0;
    run_until(2, 100, e);
    chk("t4_restart_lat", e, 26);
    bus.ch_restart[2] = 1'b1;
    tick();
    bus.ch_restart[2] = 1'b0;
    chk("t4_restart_drop", bus.ch_timeout[2], 0);
    repeat (15) tick();
    chk("t4_not_yet", bus.ch_timeout[2], 0);
    set_lim(2, 5);
    tick();
    chk("t4_lower_to", bus.ch_timeout[2], 1);
    chk("t4_lower_pulse", bus.ch_expire_p[2], 1);
    tick();
    chk("t4_single_pulse", bus.ch_expire_p[2], 0);
    set_lim(2, 20);
    tick();
    chk("t4_raise_drop", bus.ch_timeout[2], 0);
    run_until(2, 100, e);
    chk("t4_resume_lat", e, 5);
    chk("t4_repulse", bus.ch_expire_p[2], 1);
    bus.ch_run[2] = 1'b0;
    tick();

    // 5: ch3/ch4 simultaneous expiry
    set_lim(3, 200);
    set_lim(4, 200);
    bus.ch_run[4:3] = 2'b11;
    run_until(3, 300, e);
    chk("t5_latency", e, 201);
    chk("t5_both_pulse", 32'(bus.ch_expire_p[4:3]), 3);
    chk("t5_any_lag", bus.any_timeout, 0);
    tick();
    chk("t5_any_hi", bus.any_timeout, 1);
    bus.ch_run[4:3] = 2'b00;
    tick();

    // 6: asynchronous reset mid-count on ch5
    set_lim(5, 200);
    bus.ch_run[5] = 1'b1;
    repeat (100) tick();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6_async_clear", 32'({bus.ch_timeout, bus.ch_expire_p, bus.any_timeout, bus.slow_tick}), 0);
    tick();
    tick();
    rst = 1'b1;
    run_until(5, 400, e);
    chk("t6_restart_lat", e, 201);
    bus.ch_run[5] = 1'b0;
    tick();

    // Randomized phase against the model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(15) == 0) bus.ch_run[i] = ~bus.ch_run[i];
        bus.ch_restart[i] = ($urandom_range(19) == 0);
        if ($urandom_range(31) == 0) begin
          bus.ch_tick_sel[i] = ($urandom_range(7) == 0);
          set_lim(i, bus.ch_tick_sel[i] ? int'($urandom_range(2)) : int'($urandom_range(15)));
        end
      end
      tick();
    end
    bus.ch_restart = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
